axis_frame_len_stats: RTL and testbench

Per-port frame-length statistics accumulator that sits directly downstream of the AXI-stream frame length monitor. On each `frame_len_valid` pulse it updates a frame count, a total byte count, min/max length, and runt/oversize counters. Software or a management agent requests a snapshot. The block then freezes all statistics into output registers, clears the accumulators atomically, and presents the snapshot under a valid/ready handshake.

---
 rtl/axis_frame_len_stats.sv | 200 ++++++++++++++++++++
 tb/tb_axis_frame_len_stats.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats
// Per-port frame length statistics. Accumulates frame count, byte total,
// min/max length and runt/oversize counts from a length strobe. A snapshot
// request freezes the accumulated values into output registers and clears the
// accumulators in the same cycle; the snapshot is then offered under a
// valid/ready handshake.

module axis_frame_len_stats #(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int SUM_WIDTH   = 48,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic                   frame_len_valid,
  input  logic                   snap_req,
  output logic                   snap_valid,
  input  logic                   snap_ready,
  output logic [COUNT_WIDTH-1:0] stat_frame_count,
  output logic [SUM_WIDTH-1:0]   stat_byte_count,
  output logic [LEN_WIDTH-1:0]   stat_min_len,
  output logic [LEN_WIDTH-1:0]   stat_max_len,
  output logic [COUNT_WIDTH-1:0] stat_runt_count,
  output logic [COUNT_WIDTH-1:0] stat_oversize_count
);

  // Event counters share one saturating implementation; index selects the
  // qualifying condition.
  localparam int NUM_CNT    = 3;
  localparam int CNT_FRAMES = 0;
  localparam int CNT_RUNT   = 1;
  localparam int CNT_OVER   = 2;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONES = {COUNT_WIDTH{1'b1}};
  localparam logic [SUM_WIDTH-1:0]   SUM_ONES   = {SUM_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0]   LEN_ONES   = {LEN_WIDTH{1'b1}};

  // Thresholds carry one extra bit so MIN_LEN/MAX_LEN equal to 2**LEN_WIDTH
  // still compare correctly against an unsigned length.
  localparam logic [LEN_WIDTH:0] MIN_LEN_L = (LEN_WIDTH+1)'(MIN_LEN);
  localparam logic [LEN_WIDTH:0] MAX_LEN_L = (LEN_WIDTH+1)'(MAX_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                       state_reg;
  logic                         snap_valid_reg;
  logic                         capture;
  logic                         is_runt;
  logic                         is_over;
  logic [NUM_CNT-1:0]           cnt_inc;
  logic [NUM_CNT*COUNT_WIDTH-1:0] cnt_snap_flat;

  logic [SUM_WIDTH-1:0]         acc_bytes_reg;
  logic [SUM_WIDTH-1:0]         acc_bytes_next;
  logic [SUM_WIDTH:0]           bytes_wide;
  logic [LEN_WIDTH-1:0]         acc_min_reg;
  logic [LEN_WIDTH-1:0]         acc_min_next;
  logic [LEN_WIDTH-1:0]         acc_max_reg;
  logic [LEN_WIDTH-1:0]         acc_max_next;

  logic [SUM_WIDTH-1:0]         snap_bytes_reg;
  logic [LEN_WIDTH-1:0]         snap_min_reg;
  logic [LEN_WIDTH-1:0]         snap_max_reg;

  // A capture happens on a request in IDLE, or on a request that coincides
  // with the consumer accepting the current snapshot in HOLD.
  assign capture = snap_req && ((state_reg == IDLE) || snap_ready);

  // Classify the incoming length against the runt/oversize thresholds.
  always_comb begin
    is_runt = ({1'b0, frame_len} < MIN_LEN_L);
    is_over = ({1'b0, frame_len} > MAX_LEN_L);
  end

  assign cnt_inc = {is_over, is_runt, 1'b1} & {NUM_CNT{frame_len_valid}};

  // Saturating event counters with their snapshot registers. The snapshot
  // takes the value including any frame arriving in the capture cycle, so
  // that frame lands in exactly one interval.
  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
      logic [COUNT_WIDTH-1:0] cnt_reg;
      logic [COUNT_WIDTH-1:0] cnt_next;
      logic [COUNT_WIDTH-1:0] snap_reg;

      // Increment unless already pinned at all-ones.
      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_inc[gi] && (cnt_reg != COUNT_ONES)) begin
          cnt_next = cnt_reg + COUNT_WIDTH'(1);
        end
      end

      // Accumulate, or hand the running value to the snapshot and clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          snap_reg <= '0;
        end else if (capture) begin
          cnt_reg  <= '0;
          snap_reg <= cnt_next;
        end else begin
          cnt_reg  <= cnt_next;
        end
      end

      assign cnt_snap_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = snap_reg;
    end
  endgenerate

  // Next byte total (saturating) and running min/max including this frame.
  always_comb begin
    bytes_wide     = {1'b0, acc_bytes_reg} + (SUM_WIDTH+1)'(frame_len);
    acc_bytes_next = acc_bytes_reg;
    acc_min_next   = acc_min_reg;
    acc_max_next   = acc_max_reg;
    if (frame_len_valid) begin
      acc_bytes_next = bytes_wide[SUM_WIDTH] ? SUM_ONES : bytes_wide[SUM_WIDTH-1:0];
      if (frame_len < acc_min_reg) begin
        acc_min_next = frame_len;
      end
      if (frame_len > acc_max_reg) begin
        acc_max_next = frame_len;
      end
    end
  end

  // Byte/min/max accumulators: clear on capture, otherwise take the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_bytes_reg <= '0;
      acc_min_reg   <= LEN_ONES;
      acc_max_reg   <= '0;
    end else if (capture) begin
      acc_bytes_reg <= '0;
      acc_min_reg   <= LEN_ONES;
      acc_max_reg   <= '0;
    end else begin
      acc_bytes_reg <= acc_bytes_next;
      acc_min_reg   <= acc_min_next;
      acc_max_reg   <= acc_max_next;
    end
  end

  // Byte/min/max snapshot registers: load only on a capture event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bytes_reg <= '0;
      snap_min_reg   <= LEN_ONES;
      snap_max_reg   <= '0;
    end else if (capture) begin
      snap_bytes_reg <= acc_bytes_next;
      snap_min_reg   <= acc_min_next;
      snap_max_reg   <= acc_max_next;
    end
  end

  // Snapshot handshake FSM; snap_valid is a registered output of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      snap_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture) begin
            state_reg      <= HOLD;
            snap_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          // A request alongside the handshake re-captures and stays in HOLD.
          if (snap_ready && !snap_req) begin
            state_reg      <= IDLE;
            snap_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          snap_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign snap_valid          = snap_valid_reg;
  assign stat_frame_count    = cnt_snap_flat[CNT_FRAMES*COUNT_WIDTH +: COUNT_WIDTH];
  assign stat_runt_count     = cnt_snap_flat[CNT_RUNT*COUNT_WIDTH +: COUNT_WIDTH];
  assign stat_oversize_count = cnt_snap_flat[CNT_OVER*COUNT_WIDTH +: COUNT_WIDTH];
  assign stat_byte_count     = snap_bytes_reg;
  assign stat_min_len        = snap_min_reg;
  assign stat_max_len        = snap_max_reg;

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Testbench for axis_frame_len_stats. Two instances share the stimulus: one
// with default widths and one with narrow counter/sum widths so saturation is
// reachable. Expected snapshots come from a list-of-lengths model and are
// compared by a monitor when the consumer accepts a snapshot.

module tb_axis_frame_len_stats;

  typedef struct {
    longint frames;
    longint bytes;
    longint minl;
    longint maxl;
    longint runt;
    longint over;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_len = '0;
  logic        frame_len_valid = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_ready = 1'b0;

  logic        snap_valid;
  logic [31:0] stat_frame_count, stat_runt_count, stat_oversize_count;
  logic [47:0] stat_byte_count;
  logic [15:0] stat_min_len, stat_max_len;

  logic        snap_valid4;
  logic [3:0]  stat_frame_count4, stat_runt_count4, stat_oversize_count4;
  logic [15:0] stat_byte_count4;
  logic [15:0] stat_min_len4, stat_max_len4;

  int     errors = 0;
  int     checks = 0;
  int     snaps_seen = 0;
  bit     hold_m = 1'b0;
  bit     in_reset = 1'b1;
  int     cur_lens[$];
  snap_t  exp_q[$];
  snap_t  exp4_q[$];

  always #5 clk = ~clk;

  axis_frame_len_stats dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_len           (frame_len),
    .frame_len_valid     (frame_len_valid),
    .snap_req            (snap_req),
    .snap_valid          (snap_valid),
    .snap_ready          (snap_ready),
    .stat_frame_count    (stat_frame_count),
    .stat_byte_count     (stat_byte_count),
    .stat_min_len        (stat_min_len),
    .stat_max_len        (stat_max_len),
    .stat_runt_count     (stat_runt_count),
    .stat_oversize_count (stat_oversize_count)
  );

  axis_frame_len_stats #(
    .LEN_WIDTH   (16),
    .COUNT_WIDTH (4),
    .SUM_WIDTH   (16),
    .MIN_LEN     (64),
    .MAX_LEN     (1518)
  ) dut4 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_len           (frame_len),
    .frame_len_valid     (frame_len_valid),
    .snap_req            (snap_req),
    .snap_valid          (snap_valid4),
    .snap_ready          (snap_ready),
    .stat_frame_count    (stat_frame_count4),
    .stat_byte_count     (stat_byte_count4),
    .stat_min_len        (stat_min_len4),
    .stat_max_len        (stat_max_len4),
    .stat_runt_count     (stat_runt_count4),
    .stat_oversize_count (stat_oversize_count4)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Statistics of the frames collected since the last capture, with counters
  // clamped to cw bits and the byte sum clamped to sw bits.
  function automatic snap_t model_snap(input int cw, input int sw);
    snap_t  s;
    longint cmax = (longint'(1) << cw) - 1;
    longint smax = (longint'(1) << sw) - 1;
    longint n = 0, b = 0, r = 0, o = 0;
    s.minl = 65535;
    s.maxl = 0;
    foreach (cur_lens[i]) begin
      n++;
      b += cur_lens[i];
      if (cur_lens[i] < 64)   r++;
      if (cur_lens[i] > 1518) o++;
      if (cur_lens[i] < s.minl) s.minl = cur_lens[i];
      if (cur_lens[i] > s.maxl) s.maxl = cur_lens[i];
    end
    s.frames = (n > cmax) ? cmax : n;
    s.bytes  = (b > smax) ? smax : b;
    s.runt   = (r > cmax) ? cmax : r;
    s.over   = (o > cmax) ? cmax : o;
    return s;
  endfunction

  // Reference behaviour at a clock edge for the inputs applied this cycle.
  task automatic model_edge(input bit fv, input int len, input bit req, input bit rdy);
    bit cap;
    cap = req && (!hold_m || rdy);
    if (fv) cur_lens.push_back(len);
    if (cap) begin
      exp_q.push_back(model_snap(32, 48));
      exp4_q.push_back(model_snap(4, 16));
      cur_lens.delete();
      hold_m = 1'b1;
    end else if (hold_m && rdy) begin
      hold_m = 1'b0;
    end
  endtask

  task automatic step(input bit fv, input int len, input bit req, input bit rdy);
    frame_len_valid = fv;
    frame_len       = 16'(len);
    snap_req        = req;
    snap_ready      = rdy;
    @(posedge clk);
    model_edge(fv, len, req, rdy);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_valid",    snap_valid, 0);
    chk("rst_frames",   stat_frame_count, 0);
    chk("rst_bytes",    stat_byte_count, 0);
    chk("rst_min",      stat_min_len, 65535);
    chk("rst_max",      stat_max_len, 0);
    chk("rst_runt",     stat_runt_count, 0);
    chk("rst_over",     stat_oversize_count, 0);
    chk("rst_valid4",   snap_valid4, 0);
    chk("rst_frames4",  stat_frame_count4, 0);
    chk("rst_bytes4",   stat_byte_count4, 0);
    chk("rst_min4",     stat_min_len4, 65535);
    chk("rst_max4",     stat_max_len4, 0);
    chk("rst_runt4",    stat_runt_count4, 0);
    chk("rst_over4",    stat_oversize_count4, 0);
  endtask

  function automatic int rand_len();
    int b[4];
    b = '{63, 64, 1518, 1519};
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 63));
      1:       return int'($urandom_range(64, 1518));
      2:       return int'($urandom_range(1519, 9000));
      3:       return b[$urandom_range(0, 3)];
      default: return ($urandom_range(0, 1) != 0) ? 65535 : 0;
    endcase
  endfunction

  // Monitor: snap_valid must track the reference handshake state, and each
  // accepted snapshot is compared with the oldest expected one.
  always @(negedge clk) begin
    snap_t e, e4;
    if (!in_reset) begin
      chk("snap_valid",  snap_valid,  hold_m);
      chk("snap_valid4", snap_valid4, hold_m);
      if (snap_valid && snap_ready) begin
        if (exp_q.size() == 0 || exp4_q.size() == 0) begin
          chk("unexpected_snapshot", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          e4 = exp4_q.pop_front();
          snaps_seen++;
          $display("snap %0d: frames=%0d bytes=%0d min=%0d max=%0d runt=%0d over=%0d | w4 frames=%0d bytes=%0d runt=%0d over=%0d",
                   snaps_seen, stat_frame_count, stat_byte_count, stat_min_len, stat_max_len,
                   stat_runt_count, stat_oversize_count, stat_frame_count4, stat_byte_count4,
                   stat_runt_count4, stat_oversize_count4);
          chk("frames",  stat_frame_count,     e.frames);
          chk("bytes",   stat_byte_count,      e.bytes);
          chk("min",     stat_min_len,         e.minl);
          chk("max",     stat_max_len,         e.maxl);
          chk("runt",    stat_runt_count,      e.runt);
          chk("over",    stat_oversize_count,  e.over);
          chk("frames4", stat_frame_count4,    e4.frames);
          chk("bytes4",  stat_byte_count4,     e4.bytes);
          chk("min4",    stat_min_len4,        e4.minl);
          chk("max4",    stat_max_len4,        e4.maxl);
          chk("runt4",   stat_runt_count4,     e4.runt);
          chk("over4",   stat_oversize_count4, e4.over);
        end
      end
    end
  end

  initial begin
    int seq[4];

    // Power-up reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Basic snapshot: 64, 100, 1518
    step(1, 64, 0, 1);
    step(1, 100, 0, 1);
    step(1, 1518, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Runt / oversize boundaries
    seq = '{0, 63, 1519, 9000};
    foreach (seq[i]) step(1, seq[i], 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Frame in the capture cycle, then an empty back-to-back snapshot
    step(1, 200, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Consumer stalls while frames and extra requests keep arriving
    step(1, 300, 1, 0);
    for (int i = 0; i < 10; i++) step(1, rand_len(), (i % 2) == 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // 20 oversize frames: saturates the narrow instance's counters and sum
    for (int i = 0; i < 20; i++) step(1, 4000, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) != 0, rand_len(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("drained", exp_q.size(), 0);

    // Reset asserted in HOLD with non-empty statistics
    step(1, 500, 0, 1);
    step(1, 20, 0, 1);
    step(0, 0, 1, 0);
    step(1, 33, 0, 0);
    in_reset = 1'b1;
    frame_len_valid = 1'b0;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    cur_lens.delete();
    exp_q.delete();
    exp4_q.delete();
    hold_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Accumulators must have been cleared by the reset
    step(1, 70, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("final_drained", exp_q.size(), 0);
    chk("snapshots_seen_nonzero", (snaps_seen > 100) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
